// File: rtl/a2d_spi_resp.sv
// SPI mode-0 slave returning one 12-bit A2D channel per 16-bit frame.
// The channel served in a frame is the one commanded by the previous good frame.
module a2d_spi_resp #(
    parameter logic [2:0] DFLT_CHNL = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] batt,
    output logic        cmd_vld,
    output logic [2:0]  cmd_chnl,
    output logic        frm_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [2:0]  ss_q;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [1:0]  sync_vld_q;
    logic        armed_q, armed_d;

    logic [15:0] tx_q, tx_d;
    logic [13:0] rx_q, rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;

    logic        end_ok_q, end_ok_d;
    logic        end_bad_q, end_bad_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic        frm_err_q, frm_err_d;
    logic [2:0]  cmd_chnl_q, cmd_chnl_d;
    logic [2:0]  nxt_chnl_q, nxt_chnl_d;

    logic        ss_sync, ss_rise, ss_fall;
    logic        sclk_rise, sclk_fall;
    logic        mosi_sync;
    logic [11:0] chnl_data;

    // Stage 0/1 synchronise, stage 2 is the previous value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q       <= 3'b111;
            sclk_q     <= 3'b111;
            mosi_q     <= 2'b00;
            sync_vld_q <= 2'b00;
        end else begin
            ss_q       <= {ss_q[1:0], SS_n};
            sclk_q     <= {sclk_q[1:0], SCLK};
            mosi_q     <= {mosi_q[0], MOSI};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    assign ss_sync   = ss_q[1];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_sync = mosi_q[1];

    always_comb begin
        chnl_data = 12'h000;
        case (nxt_chnl_q)
            3'd0:    chnl_data = lft_ld;
            3'd4:    chnl_data = rght_ld;
            3'd5:    chnl_data = batt;
            default: chnl_data = 12'h000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            tx_q       <= 16'h0000;
            rx_q       <= 14'h0000;
            bit_cnt_q  <= 5'd0;
            end_ok_q   <= 1'b0;
            end_bad_q  <= 1'b0;
            cmd_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            cmd_chnl_q <= 3'd0;
            nxt_chnl_q <= DFLT_CHNL;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            end_ok_q   <= end_ok_d;
            end_bad_q  <= end_bad_d;
            cmd_vld_q  <= cmd_vld_d;
            frm_err_q  <= frm_err_d;
            cmd_chnl_q <= cmd_chnl_d;
            nxt_chnl_q <= nxt_chnl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        end_ok_d   = 1'b0;
        end_bad_d  = 1'b0;
        cmd_vld_d  = end_ok_q;
        frm_err_d  = end_bad_q;
        cmd_chnl_d = cmd_chnl_q;
        nxt_chnl_d = nxt_chnl_q;
        // A frame may only start once SS_n has genuinely been seen high after reset.
        armed_d    = armed_q | (sync_vld_q[1] & ss_sync);

        if (end_ok_q) begin
            cmd_chnl_d = rx_q[13:11];
            nxt_chnl_d = rx_q[13:11];
        end

        case (state_q)
            IDLE: begin
                tx_d = 16'h0000;
                if (ss_fall && armed_q) begin
                    state_d   = SHIFT;
                    tx_d      = {4'b0000, chnl_data};
                    bit_cnt_d = 5'd0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    tx_d    = 16'h0000;
                    if (bit_cnt_q == 5'd16) begin
                        end_ok_d = 1'b1;
                    end else begin
                        end_bad_d = 1'b1;
                    end
                end else if (!ss_sync) begin
                    // Frame bits 15:14 are never decoded, so only 14 bits are kept.
                    if (sclk_rise) begin
                        rx_d = {rx_q[12:0], mosi_sync};
                        if (bit_cnt_q != 5'd31) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 16'h0000;
            end
        endcase
    end

    assign MISO     = tx_q[15];
    assign cmd_vld  = cmd_vld_q;
    assign frm_err  = frm_err_q;
    assign cmd_chnl = cmd_chnl_q;

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 Parameter DFLT_CHNL, default 3'd0: channel whose data is returned in the first frame after reset.
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 SS_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-005 SCLK  input  1  SPI serial clock, asynchronous to clk.
REQ-006 MOSI  input  1  SPI serial data into the block.
REQ-007 MISO  output  1  SPI serial data out of the block, MSB first.
REQ-008 lft_ld  input  12  left load-cell value, served on channel 0.
REQ-009 rght_ld  input  12  right load-cell value, served on channel 4.
REQ-010 batt  input  12  battery value, served on channel 5.
REQ-011 cmd_vld  output  1  one-clk pulse when a complete 16-bit command frame has been received.
REQ-012 cmd_chnl  output  3  channel decoded from the last complete frame.
REQ-013 frm_err  output  1  one-clk pulse when a frame ends with a bit count other than 16.

Function
REQ-014 Double-flop synchronisers shall be used:
- SS_n and SCLK shall reset to 1; MOSI shall reset to 0.
- One extra stage on SS_n and on SCLK shall provide edge detection.
REQ-015 Supported SPI timing:
- Mode 0 (MOSI sampled on SCLK rise, MISO changed on SCLK fall), 16-bit frames, MSB first.
- SCLK high and low times shall each be at least 4 clk periods.
REQ-016 State machine: states IDLE and SHIFT.
- IDLE -> SHIFT on a synchronised SS_n fall.
- SHIFT -> IDLE on a synchronised SS_n rise.
REQ-017 On the IDLE->SHIFT transition:
- tx_shft shall be loaded with {4'b0000, data of nxt_chnl}; the data value shall be snapshotted at this cycle.
- The bit counter shall be cleared.
REQ-018 Channel map: 0 = lft_ld, 4 = rght_ld, 5 = batt; all other channels return 12'h000.
REQ-019 In SHIFT, on each synchronised SCLK rise:
- rx_shft shall become {rx_shft[14:0], MOSI_sync}.
- The 5-bit bit counter shall increment, saturating at 31.
REQ-020 In SHIFT, on each synchronised SCLK fall, tx_shft shall shift left and fill with 0.
REQ-021 MISO shall equal tx_shft[15] at all times; in IDLE, tx_shft shall be 0.
REQ-022 Frame end on SS_n rise with bit count == 16:
- cmd_chnl and nxt_chnl shall both take rx_shft[13:11].
- cmd_vld shall pulse for exactly one cycle, 3 clk after the raw SS_n rise is first sampled.
REQ-023 Frame end on SS_n rise with bit count != 16:
- frm_err shall pulse for one cycle.
- nxt_chnl and cmd_chnl shall be unchanged; no cmd_vld.
REQ-024 Response pipelining: the reply in frame N carries the channel commanded in frame N-1.
REQ-025 An SS_n rise and an SCLK edge detected in the same clk: the SS_n rise takes priority and the SCLK edge is ignored.
REQ-026 SCLK edges while SS_n_sync is high shall be ignored.
REQ-027 If SS_n is already low at reset release, that frame shall be ignored:
- A frame starts only after synchronised SS_n has been observed high for at least 1 clk.

Reset
REQ-028 While rst is high, all of the following shall hold:
- State = IDLE.
- tx_shft, rx_shft and the bit counter = 0.
- MISO = 0, cmd_vld = 0, frm_err = 0, cmd_chnl = 0.
- nxt_chnl = DFLT_CHNL.
REQ-029 rst asserted mid-frame shall discard the frame with no cmd_vld or frm_err, including after rst is released.

Verification
REQ-030 The bench shall cover the following directed scenarios, with SCLK = clk/32:
- Reset, lft_ld=12'hA5C, frame MOSI=16'h0000 -> MISO=16'h0A5C; cmd_vld pulse; cmd_chnl=0.
- batt=12'h9C3, frame 16'h2800, then frame 16'h0000 -> second MISO=16'h09C3; cmd_chnl 5 then 0.
- Prior frame 16'h2000, rght_ld=12'h123, rght_ld changed to 12'hFFF after bit 3 -> MISO=16'h0123.
- Prior channel 5; frame aborted after 9 SCLKs -> frm_err pulse, no cmd_vld; next frame returns batt.
- rst pulsed after 8 bits with SS_n held low -> MISO=0, no pulses; next full frame returns DFLT_CHNL data.
- Frame 16'h3800, then frame 16'h0000 -> second MISO=16'h0000; cmd_chnl=7 after the first frame.
